// File: rtl/scoreboard_pkg.sv
// scoreboard_unit shared types: register index, latency class, countdown width.
// Used by scoreboard_unit and sb_entry.
package scoreboard_pkg;

  localparam int CNT_W = 3;

  typedef logic [3:0] regidx_t;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_MUL,
    CLS_NONE
  } lat_class_t;

endpackage

// File: rtl/sb_entry.sv
// One register's scoreboard slot: pending bit plus forwarding countdown.
// Priority: reset, set (issue), clear (writeback), decrement.
module sb_entry
  import scoreboard_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic             set,
  input  logic [CNT_W-1:0] load,
  input  logic             clr,
  output logic             pending,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (nRST) begin
      pending <= 1'b0;
      cnt     <= '0;
    end else if (set) begin
      pending <= 1'b1;
      cnt     <= load;
    end else if (clr) begin
      pending <= 1'b0;
      cnt     <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/scoreboard_unit.sv
// Issue-stage register scoreboard with load/mul latency tracking.
// Optional stall statistics counter enabled by SCOREBOARD_STATS_EN.
module scoreboard_unit
  import scoreboard_pkg::*;
#(
  parameter int NREGS    = 16,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 5,
  parameter int ALU_LAT  = 0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             issue_valid,
  input  logic [3:0]       issue_rs1,
  input  logic [3:0]       issue_rs2,
  input  logic [3:0]       issue_rd,
  input  logic [1:0]       issue_class,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic [3:0]       wb_rd,
  output logic             stall,
  output logic [NREGS-1:0] pending_mask,
  output logic [15:0]      stall_count
);

  logic [NREGS-1:0]            pend;
  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]            mul_busy;
  logic [CNT_W-1:0]            lat;
  lat_class_t                  cls;
  regidx_t                     rs1, rs2, rd;
  logic                        writes, haz1, haz2, waw, strc, accept;

  assign cls = lat_class_t'(issue_class);
  assign rs1 = issue_rs1;
  assign rs2 = issue_rs2;
  assign rd  = issue_rd;

  assign pend[0] = 1'b0;
  assign cnt[0]  = '0;

  always_comb begin
    writes = (cls != CLS_NONE) && (rd != '0);
    haz1   = (rs1 != '0) && pend[rs1] && (cnt[rs1] != '0);
    haz2   = (rs2 != '0) && pend[rs2] && (cnt[rs2] != '0);
    waw    = writes && pend[rd];
    strc   = (cls == CLS_MUL) && (mul_busy != '0);
    stall  = issue_valid && !flush && (haz1 || haz2 || waw || strc);
    accept = issue_valid && !flush && !stall && writes;
    lat    = CNT_W'(ALU_LAT);
    unique case (1'b1)
      cls == CLS_LOAD: lat = CNT_W'(LOAD_LAT);
      cls == CLS_MUL:  lat = CNT_W'(MUL_LAT);
      default:         lat = CNT_W'(ALU_LAT);
    endcase
  end

  for (genvar r = 1; r < NREGS; r++) begin : g_ent
    sb_entry u_ent (
      .CLK     (CLK),
      .nRST    (nRST),
      .set     (accept && (rd == regidx_t'(r))),
      .load    (lat),
      .clr     (wb_valid && (wb_rd == regidx_t'(r))),
      .pending (pend[r]),
      .cnt     (cnt[r])
    );
  end

  always_ff @(posedge CLK) begin
    if (nRST)
      mul_busy <= '0;
    else if (accept && (cls == CLS_MUL))
      mul_busy <= CNT_W'(MUL_LAT);
    else if (mul_busy != '0)
      mul_busy <= mul_busy - 1'b1;
  end

  assign pending_mask = pend;

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge CLK) begin
    if (nRST)
      stall_count <= '0;
    else if (stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_scoreboard_unit.sv
// Directed self-checking bench for scoreboard_unit.
// Stall-counter expectations follow SCOREBOARD_STATS_EN.
module tb_scoreboard_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        issue_valid;
  logic [3:0]  issue_rs1, issue_rs2, issue_rd;
  logic [1:0]  issue_class;
  logic        flush, wb_valid;
  logic [3:0]  wb_rd;
  logic        stall;
  logic [15:0] pending_mask;
  logic [15:0] stall_count;

  int tests = 0;
  int fails = 0;

`ifdef SCOREBOARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 CLK = ~CLK;

  scoreboard_unit dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .issue_valid  (issue_valid),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_rd     (issue_rd),
    .issue_class  (issue_class),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .stall        (stall),
    .pending_mask (pending_mask),
    .stall_count  (stall_count)
  );

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic present(input logic v, input logic [3:0] r1,
                         input logic [3:0] r2, input logic [3:0] rd,
                         input logic [1:0] c, input logic f);
    issue_valid = v;
    issue_rs1   = r1;
    issue_rs2   = r2;
    issue_rd    = rd;
    issue_class = c;
    flush       = f;
    #1;
  endtask

  task automatic idle();
    present(1'b0, 4'd0, 4'd0, 4'd0, 2'd3, 1'b0);
    wb_valid = 1'b0;
    wb_rd    = 4'd0;
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b1;
    tick();
    nRST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (pending_mask !== 16'h0) begin
      fails++;
      $display("FAIL reset_mask got %h want 0000", pending_mask);
    end
    tests++;
    if (stall_count !== 16'h0) begin
      fails++;
      $display("FAIL reset_count got %h want 0000", stall_count);
    end
    present(1'b1, 4'd3, 4'd0, 4'd3, 2'd1, 1'b0);
    tick();
    tests++;
    if (pending_mask !== 16'h0008) begin
      fails++;
      $display("FAIL reset_pre got %h want 0008", pending_mask);
    end
    idle();
    present(1'b1, 4'd0, 4'd0, 4'd8, 2'd1, 1'b0);
    nRST = 1'b1;
    tick();
    nRST = 1'b0;
    idle();
    tests++;
    if (pending_mask !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid got %h want 0000", pending_mask);
    end
    present(1'b1, 4'd3, 4'd0, 4'd0, 2'd3, 1'b0);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_reader got %b want 0", stall);
    end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    present(1'b1, 4'd0, 4'd0, 4'd5, 2'd1, 1'b0);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL lu_issue got %b want 0", stall);
    end
    tick();
    present(1'b1, 4'd5, 4'd0, 4'd0, 2'd3, 1'b0);
    tests++;
    if (stall !== 1'b1 || pending_mask !== 16'h0020) begin
      fails++;
      $display("FAIL lu_c1 got %b/%h want 1/0020", stall, pending_mask);
    end
    tick();
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL lu_c2 got %b want 1", stall);
    end
    tick();
    #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL lu_c3 got %b want 0", stall);
    end
    tick();
    idle();
    tests++;
    if (stall_count !== (STATS ? 16'd2 : 16'd0)) begin
      fails++;
      $display("FAIL lu_count got %0d want %0d", stall_count,
               STATS ? 2 : 0);
    end
    wb_valid = 1'b1;
    wb_rd    = 4'd5;
    tick();
    idle();
    tests++;
    if (pending_mask !== 16'h0) begin
      fails++;
      $display("FAIL lu_wb got %h want 0000", pending_mask);
    end
  endtask

  task automatic test_alu();
    do_reset();
    present(1'b1, 4'd0, 4'd0, 4'd4, 2'd0, 1'b0);
    tick();
    present(1'b1, 4'd0, 4'd4, 4'd0, 2'd3, 1'b0);
    tests++;
    if (stall !== 1'b0 || pending_mask !== 16'h0010) begin
      fails++;
      $display("FAIL alu_b2b got %b/%h want 0/0010", stall, pending_mask);
    end
    tick();
    idle();
    tick();
    tests++;
    if (pending_mask !== 16'h0010) begin
      fails++;
      $display("FAIL alu_hold got %h want 0010", pending_mask);
    end
    wb_valid = 1'b1;
    wb_rd    = 4'd4;
    tick();
    idle();
    tests++;
    if (pending_mask !== 16'h0) begin
      fails++;
      $display("FAIL alu_wb got %h want 0000", pending_mask);
    end
  endtask

  task automatic test_mul();
    int n;
    do_reset();
    present(1'b1, 4'd0, 4'd0, 4'd6, 2'd2, 1'b0);
    tick();
    present(1'b1, 4'd0, 4'd0, 4'd7, 2'd2, 1'b0);
    n = 0;
    for (int i = 0; i < 10 && stall; i++) begin
      n++;
      tick();
      #1;
    end
    tests++;
    if (stall !== 1'b0 || n != 5) begin
      fails++;
      $display("FAIL mul_struct got %0d stalls want 5", n);
    end
    tick();
    idle();
    tests++;
    if (pending_mask !== 16'h00C0) begin
      fails++;
      $display("FAIL mul_accept got %h want 00c0", pending_mask);
    end
    for (int i = 0; i < 6; i++) tick();
    present(1'b1, 4'd0, 4'd0, 4'd6, 2'd2, 1'b0);
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL mul_waw got %b want 1", stall);
    end
    wb_valid = 1'b1;
    wb_rd    = 4'd6;
    tick();
    wb_valid = 1'b0;
    wb_rd    = 4'd0;
    #1;
    tests++;
    if (stall !== 1'b0 || pending_mask !== 16'h0080) begin
      fails++;
      $display("FAIL mul_waw_rel got %b/%h want 0/0080",
               stall, pending_mask);
    end
    tick();
    idle();
    tests++;
    if (pending_mask !== 16'h00C0) begin
      fails++;
      $display("FAIL mul_reissue got %h want 00c0", pending_mask);
    end
  endtask

  task automatic test_reg0();
    do_reset();
    present(1'b1, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0);
    tick();
    present(1'b1, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0);
    tests++;
    if (stall !== 1'b0 || pending_mask !== 16'h0) begin
      fails++;
      $display("FAIL r0 got %b/%h want 0/0000", stall, pending_mask);
    end
    present(1'b1, 4'd0, 4'd0, 4'd9, 2'd1, 1'b0);
    tick();
    idle();
    wb_valid = 1'b1;
    wb_rd    = 4'd0;
    tick();
    wb_rd    = 4'd11;
    tick();
    idle();
    tests++;
    if (pending_mask !== 16'h0200) begin
      fails++;
      $display("FAIL r0_wb got %h want 0200", pending_mask);
    end
  endtask

  task automatic test_flush();
    do_reset();
    present(1'b1, 4'd0, 4'd0, 4'd2, 2'd1, 1'b0);
    tick();
    present(1'b1, 4'd2, 4'd0, 4'd10, 2'd1, 1'b1);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_stall got %b want 0", stall);
    end
    tick();
    present(1'b1, 4'd2, 4'd0, 4'd10, 2'd1, 1'b0);
    tests++;
    if (pending_mask !== 16'h0004 || stall !== 1'b1) begin
      fails++;
      $display("FAIL flush_rec got %h/%b want 0004/1",
               pending_mask, stall);
    end
    idle();
  endtask

  initial begin
    nRST = 1'b1;
    idle();
    tick();
    test_reset();
    test_load_use();
    test_alu();
    test_mul();
    test_reg0();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
